// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Writable program memory with a byte-stream load port.
//                The CPU side reads like a ROM: combinational read by
//                address. The load side takes DEPTH program bytes plus one
//                checksum byte over valid/ready. The CPU stays held in reset
//                until a load passes its checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] C_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] C_ONE  = (ADDR_WIDTH+1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    hold_q, hold_d;
    logic                    w_accept;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // A restart request masks ready so a coincident byte is never taken.
    assign in_ready = ((state_q == S_LOAD) || (state_q == S_CHECK)) && !load_start;
    assign w_accept = in_valid && in_ready;

    // CPU read port: purely combinational, old value visible during a write.
    assign data       = mem_q[address];
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign byte_count = count_q;

    // Next-state and registered-output logic for the load sequencer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        w_wr_en = 1'b0;
        if (load_start) begin
            state_d = S_LOAD;
            count_d = '0;
            sum_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (w_accept) begin
                        w_wr_en = 1'b1;
                        sum_d   = sum_q + in_data;
                        count_d = count_q + C_ONE;
                        if (count_q == C_LAST) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    // Checksum byte only compares; count stays at DEPTH.
                    if (w_accept) begin
                        if (in_data == sum_q) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            hold_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE, RUN and ERROR wait for load_start or reset.
                end
            endcase
        end
    end

    // Sequencer state and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= HOLD_AT_RESET;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // Program memory: cleared by reset, filled in ascending address order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            mem_q[count_q[ADDR_WIDTH-1:0]] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Randomized scoreboard bench for prog_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] address = 4'h0;
    logic [7:0] data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;
    logic [4:0] byte_count;

    prog_loader #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (8),
        .DEPTH        (16),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_start(load_start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .address   (address),
        .data      (data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error),
        .byte_count(byte_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rdy;
        logic [7:0] dat;
        logic       hold;
        logic       done;
        logic       err;
        logic [4:0] cnt;
        logic [3:0] adr;
        int         phase;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   phase  = 0;

    // Reference model: program image, bytes of current load, status flags.
    logic [7:0] m_mem [16];
    logic [7:0] m_bytes[$];
    bit         m_loading;
    bit         m_hold, m_done, m_err;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_bytes.delete();
        m_loading = 1'b0;
        m_hold = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(input bit ls, input bit acc, input logic [7:0] d);
        int s;
        if (ls) begin
            m_loading = 1'b1;
            m_bytes.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
            m_hold = 1'b1;
        end else if (acc) begin
            if (m_bytes.size() < 16) begin
                m_mem[m_bytes.size()] = d;
                m_bytes.push_back(d);
            end else begin
                s = 0;
                foreach (m_bytes[i]) s += int'(m_bytes[i]);
                s = s % 256;
                if (int'(d) == s) begin
                    m_done = 1'b1;
                    m_hold = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_loading = 1'b0;
            end
        end
    endfunction

    // One clock cycle of stimulus; expected view for this cycle is queued.
    task automatic cyc(input bit ls, input bit v, input logic [7:0] d, input int adr);
        exp_t e;
        logic [3:0] a;
        a = (adr < 0) ? 4'($urandom_range(0, 15)) : 4'(adr);
        load_start = ls;
        in_valid   = v;
        in_data    = d;
        address    = a;
        e.rdy   = m_loading && !ls;
        e.dat   = m_mem[a];
        e.hold  = m_hold;
        e.done  = m_done;
        e.err   = m_err;
        e.cnt   = 5'(m_bytes.size());
        e.adr   = a;
        e.phase = phase;
        sb.push_back(e);
        model_step(ls, v && e.rdy, d);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), -1);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) cyc(1'b0, 1'b0, 8'($urandom), a);
    endtask

    task automatic send(input logic [7:0] d, input int maxgap);
        int g;
        g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        for (int i = 0; i < g; i++) cyc(1'b0, 1'b0, 8'($urandom), -1);
        cyc(1'b0, 1'b1, d, -1);
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        model_reset();
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Full load of 16 random bytes with optional gaps and a good/bad checksum.
    task automatic rand_load(input bit good, input int maxgap);
        logic [7:0] b;
        logic [7:0] s;
        s = 8'h00;
        cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), -1);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            s = s + b;
            send(b, maxgap);
        end
        send(good ? s : (s ^ 8'(1 << $urandom_range(0, 7))), maxgap);
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (in_ready !== e.rdy || data !== e.dat || cpu_hold !== e.hold ||
                load_done !== e.done || load_error !== e.err || byte_count !== e.cnt) begin
                failed++;
                $display("FAIL cycle_check phase=%0d t=%0t got rdy=%b data[%h]=%h hold=%b done=%b err=%b cnt=%0d expected rdy=%b data=%h hold=%b done=%b err=%b cnt=%0d",
                         e.phase, $time, in_ready, e.adr, data, cpu_hold, load_done, load_error,
                         byte_count, e.rdy, e.dat, e.hold, e.done, e.err, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        failed++;
        $display("FAIL watchdog: simulation time limit expired");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and IDLE ignores valid bytes.
        phase = 0;
        do_reset(3);
        sweep();
        idle_cycles(4);

        // Good load 0x00..0x0F, checksum 0x78.
        phase = 1;
        cyc(1'b1, 1'b0, 8'h00, -1);
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        send(8'h78, 0);
        idle_cycles(4);
        sweep();

        // Same load with bad checksum 0x79; later bytes ignored.
        phase = 2;
        cyc(1'b1, 1'b0, 8'h00, -1);
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        send(8'h79, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom), -1);
        sweep();

        // Gapped load of 0xA0 everywhere, checksum 0x00.
        phase = 3;
        cyc(1'b1, 1'b0, 8'h00, -1);
        for (int i = 0; i < 16; i++) send(8'hA0, 3);
        send(8'h00, 3);
        sweep();

        // Reset after five accepted bytes, then a good load.
        phase = 4;
        cyc(1'b1, 1'b0, 8'h00, -1);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1);
        do_reset(2);
        sweep();
        rand_load(1'b1, 0);
        sweep();

        // Restart during RUN with a coincident valid byte.
        phase = 5;
        cyc(1'b1, 1'b1, 8'h55, -1);
        idle_cycles(2);
        sweep();

        // Randomized sessions: good/bad loads, gaps, restarts mid-load.
        phase = 6;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc(1'b1, 1'b0, 8'h00, -1);
                for (int i = 0; i < int'($urandom_range(1, 10)); i++) send(8'($urandom), 2);
            end
            rand_load(1'($urandom_range(0, 1)), 2);
            idle_cycles(3);
            sweep();
        end

        repeat (3) @(posedge clock);
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writable 16x8 program memory with a byte-stream load port.
- Used in place of the fixed program ROM so programs can be loaded without resynthesis.
- The CPU side is identical to the ROM: 4-bit address in, 8-bit data out, combinational read.
- The load side accepts DEPTH program bytes plus one checksum byte over a valid/ready stream. It holds the CPU in reset until a load passes its checksum.

Parameters:
- ADDR_WIDTH, 4, CPU address width.
- DATA_WIDTH, 8, instruction byte width.
- DEPTH, 16, number of program bytes; must equal 2**ADDR_WIDTH.
- HOLD_AT_RESET, 1, value of cpu_hold after reset (1 = CPU held until first good load; 0 = CPU runs all-zero program).

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all state including memory.
- load_start, input, 1, single-cycle pulse; begins a new load from any state.
- in_valid, input, 1, load byte valid.
- in_data, input, DATA_WIDTH, load byte.
- in_ready, output, 1, loader accepts a byte this cycle.
- address, input, ADDR_WIDTH, CPU fetch address.
- data, output, DATA_WIDTH, mem[address], combinational.
- cpu_hold, output, 1, 1 = CPU must be held in reset.
- load_done, output, 1, last load passed its checksum.
- load_error, output, 1, last load failed its checksum.
- byte_count, output, ADDR_WIDTH+1, program bytes accepted in the current load (0..DEPTH).

Behaviour:
- Reset (reset=0, asynchronous):
  - all memory words = 0; state IDLE; byte_count = 0; running sum = 0.
  - load_done = 0, load_error = 0, cpu_hold = HOLD_AT_RESET.
  - Reset mid-load discards the partial load; memory is zeroed.
- States:
  - IDLE: in_ready = 0; outputs hold their reset values.
  - LOAD: in_ready = 1; cpu_hold = 1.
  - CHECK: in_ready = 1; cpu_hold = 1.
  - RUN: in_ready = 0; cpu_hold = 0; load_done = 1.
  - ERROR: in_ready = 0; cpu_hold = 1; load_error = 1.
- Transitions:
  - Any state, on load_start=1 → LOAD. At the same edge: byte_count = 0, sum = 0, load_done = 0, load_error = 0, cpu_hold = 1.
  - LOAD, accept with byte_count = DEPTH-1 → CHECK.
  - CHECK, accept with in_data == sum → RUN; otherwise → ERROR.
  - RUN, ERROR: remain until load_start or reset.
- Accept = in_valid & in_ready.
  - in_ready is forced to 0 in any cycle where load_start = 1, so load_start wins over a simultaneous byte.
- LOAD accept:
  - mem[byte_count[ADDR_WIDTH-1:0]] = in_data.
  - sum = (sum + in_data) mod 2**DATA_WIDTH.
  - byte_count += 1.
  - Bytes are written strictly in ascending address order 0..DEPTH-1.
- CHECK accept: compares only; memory is not written and byte_count stays at DEPTH.
- Stalls: in_valid low for any number of cycles inserts gaps with no state change. in_data is ignored when no accept occurs.
- Checksum latency: with the checksum accepted at edge k, cpu_hold falls and load_done rises immediately after edge k. The CPU leaves reset at edge k+1.
- Reload from RUN: cpu_hold rises immediately after the edge sampling load_start.
- Memory on reload: old contents remain until overwritten byte by byte. A failed load leaves partially new contents with cpu_hold = 1.
- Read port:
  - data is purely combinational from address and memory.
  - A read of the address being written in the same cycle returns the old value; the new value is visible after the edge.
  - The read port is valid in every state, including reset.
- Outputs other than data and in_ready are registered. in_ready is a function of state and load_start only.

Test Plan:
- Reset behaviour: release reset with HOLD_AT_RESET=1 → data = 0x00 at every address, cpu_hold = 1, load_done = 0, load_error = 0, in_ready = 0.
- Good load:
  - Stimulus: load_start, bytes 0x00..0x0F back-to-back, then checksum 0x78.
  - Response: byte_count steps 0..16; mem[i] = i; cpu_hold = 0 and load_done = 1 after the checksum edge.
- Bad checksum: same load with checksum 0x79 → state ERROR, load_error = 1, cpu_hold = 1, in_ready = 0; further bytes ignored; mem[i] = i.
- Backpressure and gaps:
  - Stimulus: bytes 0xA0 at all 16 addresses with random in_valid gaps, then checksum 0x00 (16×0xA0 mod 256 = 0x00).
  - Response: load_done = 1; all words = 0xA0; no duplicate or skipped writes.
- Reset mid-load: assert reset after 5 accepted bytes → all words 0x00, byte_count = 0, state IDLE; a subsequent full good load succeeds.
- Restart priority:
  - Stimulus: load_start in the same cycle as in_valid during RUN.
  - Response: in_ready = 0 that cycle; byte not written; cpu_hold = 1 and load_done = 0 from the next cycle; byte_count = 0.
